// File: rtl/mem_arb_pkg.sv
// Shared state encoding and constants for the mem_arbiter slice.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IFU_WAIT = 2'd1,
        LSU_WAIT = 2'd2
    } arb_state_e;

    localparam logic [2:0]  IFU_MEM_TYPE   = 3'b010;
    localparam logic [31:0] TIMEOUT_POISON = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arb_pick.sv
// IFU/LSU tie resolution. MEM_ARB_RR_EN selects round-robin; otherwise the LSU
// always wins a tie.
module mem_arb_pick (
    input  logic       ifu_req_i,
    input  logic       lsu_req_i,
    input  logic       last_lsu_i,
    output logic [1:0] gnt_o
);

    logic lsu_wins;

`ifdef MEM_ARB_RR_EN
    // On a tie the LSU only wins when the IFU was granted last.
    assign lsu_wins = lsu_req_i && (!ifu_req_i || !last_lsu_i);
`else
    logic unused_last_lsu;
    assign unused_last_lsu = last_lsu_i;
    assign lsu_wins        = lsu_req_i;
`endif

    // gnt_o[0] = IFU, gnt_o[1] = LSU
    assign gnt_o = {lsu_wins, ifu_req_i && !lsu_wins};

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (IFU/LSU) single-outstanding memory arbiter with ack timeout.
// Tie policy set in mem_arb_pick via MEM_ARB_RR_EN (default: LSU priority).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_gnt,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,

    input  logic              lsu_req,
    input  logic              lsu_we,
    input  logic [2:0]        lsu_type,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,

    output logic              mem_req,
    output logic              mem_we,
    output logic [2:0]        mem_type,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              last_lsu_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        type_q;
    logic              we_q;
    logic              ifu_gnt_q, lsu_gnt_q;
    logic              ifu_rvalid_q, lsu_rvalid_q;
    logic              err_q;
    logic [DATA_W-1:0] ifu_rdata_q, lsu_rdata_q;

    logic [1:0]        pick;
    logic              timed_out;
    logic [DATA_W-1:0] resp_d;

    mem_arb_pick u_pick (
        .ifu_req_i  (ifu_req),
        .lsu_req_i  (lsu_req),
        .last_lsu_i (last_lsu_q),
        .gnt_o      (pick)
    );

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Ack takes precedence over a simultaneous timeout; stores return zero.
    always_comb begin
        resp_d = DATA_W'(TIMEOUT_POISON);
        if (mem_ack) begin
            resp_d = we_q ? '0 : mem_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_lsu_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            type_q       <= '0;
            we_q         <= 1'b0;
            ifu_gnt_q    <= 1'b0;
            lsu_gnt_q    <= 1'b0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            err_q        <= 1'b0;
            ifu_rdata_q  <= '0;
            lsu_rdata_q  <= '0;
        end else begin
            ifu_gnt_q    <= 1'b0;
            lsu_gnt_q    <= 1'b0;
            ifu_rvalid_q <= 1'b0;
            lsu_rvalid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (pick[1]) begin
                        state_q    <= LSU_WAIT;
                        lsu_gnt_q  <= 1'b1;
                        last_lsu_q <= 1'b1;
                        addr_q     <= lsu_addr;
                        wdata_q    <= lsu_wdata;
                        type_q     <= lsu_type;
                        we_q       <= lsu_we;
                    end else if (pick[0]) begin
                        state_q    <= IFU_WAIT;
                        ifu_gnt_q  <= 1'b1;
                        last_lsu_q <= 1'b0;
                        addr_q     <= ifu_addr;
                        wdata_q    <= '0;
                        type_q     <= IFU_MEM_TYPE;
                        we_q       <= 1'b0;
                    end
                end
                IFU_WAIT, LSU_WAIT: begin
                    if (mem_ack || timed_out) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        err_q   <= !mem_ack;
                        if (state_q == IFU_WAIT) begin
                            ifu_rvalid_q <= 1'b1;
                            ifu_rdata_q  <= resp_d;
                        end else begin
                            lsu_rvalid_q <= 1'b1;
                            lsu_rdata_q  <= resp_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy       = (state_q != IDLE);
    assign mem_req    = busy;
    assign mem_we     = we_q && busy;
    assign mem_type   = type_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign ifu_gnt    = ifu_gnt_q;
    assign lsu_gnt    = lsu_gnt_q;
    assign ifu_rvalid = ifu_rvalid_q;
    assign lsu_rvalid = lsu_rvalid_q;
    assign ifu_rdata  = ifu_rdata_q;
    assign lsu_rdata  = lsu_rdata_q;
    assign err        = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TMO = 4;
`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ifu_req = 1'b0;
    logic [AW-1:0] ifu_addr = '0;
    logic          ifu_gnt, ifu_rvalid;
    logic [DW-1:0] ifu_rdata;
    logic          lsu_req = 1'b0, lsu_we = 1'b0;
    logic [2:0]    lsu_type = '0;
    logic [AW-1:0] lsu_addr = '0;
    logic [DW-1:0] lsu_wdata = '0;
    logic          lsu_gnt, lsu_rvalid;
    logic [DW-1:0] lsu_rdata;
    logic          mem_req, mem_we;
    logic [2:0]    mem_type;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          busy, err;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
        .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_type(lsu_type),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_type(mem_type),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: who owns memory, for how long, and what it returns.
    int          m_owner;   // 0 none, 1 IFU, 2 LSU
    int          m_age;
    bit          m_last_lsu;
    bit          m_to_lsu;
    logic [31:0] m_addr, m_wdata, m_resp;
    logic [2:0]  m_type;
    bit          m_we;
    bit          e_ifu_gnt, e_lsu_gnt, e_ifu_rv, e_lsu_rv, e_err;
    logic [31:0] e_ifu_rdata, e_lsu_rdata;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = 0; m_age = 0; m_last_lsu = 1'b0;
            m_addr = '0; m_wdata = '0; m_type = '0; m_we = 1'b0;
            e_ifu_gnt = 0; e_lsu_gnt = 0; e_ifu_rv = 0; e_lsu_rv = 0; e_err = 0;
            e_ifu_rdata = '0; e_lsu_rdata = '0;
        end else begin
            e_ifu_gnt = 0; e_lsu_gnt = 0; e_ifu_rv = 0; e_lsu_rv = 0; e_err = 0;
            if (m_owner == 0) begin
                if (ifu_req || lsu_req) begin
                    m_to_lsu   = lsu_req && !(ifu_req && RR && m_last_lsu);
                    m_owner    = m_to_lsu ? 2 : 1;
                    m_age      = 0;
                    m_last_lsu = m_to_lsu;
                    if (m_to_lsu) begin
                        m_addr = lsu_addr; m_wdata = lsu_wdata; m_type = lsu_type; m_we = lsu_we;
                        e_lsu_gnt = 1;
                    end else begin
                        m_addr = ifu_addr; m_type = 3'b010; m_we = 0;
                        e_ifu_gnt = 1;
                    end
                end
            end else begin
                m_age++;
                if (mem_ack || m_age == TMO) begin
                    m_resp = mem_ack ? (m_we ? 32'h0 : mem_rdata) : 32'hDEADBEEF;
                    e_err  = !mem_ack;
                    if (m_owner == 1) begin
                        e_ifu_rv = 1; e_ifu_rdata = m_resp;
                    end else begin
                        e_lsu_rv = 1; e_lsu_rdata = m_resp;
                    end
                    m_owner = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy",       busy,       m_owner != 0);
        chk("mem_req",    mem_req,    m_owner != 0);
        chk("ifu_gnt",    ifu_gnt,    e_ifu_gnt);
        chk("lsu_gnt",    lsu_gnt,    e_lsu_gnt);
        chk("ifu_rvalid", ifu_rvalid, e_ifu_rv);
        chk("lsu_rvalid", lsu_rvalid, e_lsu_rv);
        chk("err",        err,        e_err);
        chk("ifu_rdata",  ifu_rdata,  e_ifu_rdata);
        chk("lsu_rdata",  lsu_rdata,  e_lsu_rdata);
        if (m_owner != 0 || rst) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_type", mem_type, m_type);
            chk("mem_we",   mem_we,   m_we);
            if (m_we || rst) chk("mem_wdata", mem_wdata, m_wdata);
        end
    end

    task automatic wait_gnt(output int who);
        who = -1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (ifu_gnt || lsu_gnt) begin
                who = lsu_gnt ? 1 : 0;
                break;
            end
        end
        if (who < 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL grant_wait: no grant within 6 cycles, required one");
        end
    endtask

    int who;
    int exp_who[6];
    bit nxt_ifu[6];
    bit nxt_lsu[6];

    initial begin
        // round:          0  1  2  3  4  5   (1 = LSU)
        exp_who = RR ? '{1, 0, 1, 0, 1, 0} : '{1, 0, 1, 1, 1, 1};
        nxt_ifu = '{1, 1, 1, 1, 1, 0};
        nxt_lsu = '{0, 1, 1, 1, 1, 0};

        #1 rst = 1'b1;
        tick(); tick();
        chk("rst_busy",    busy,      1'b0);
        chk("rst_mem_req", mem_req,   1'b0);
        chk("rst_mem_we",  mem_we,    1'b0);
        chk("rst_lsu_rd",  lsu_rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Ties from reset: LSU first, then IFU; then four back-to-back ties.
        ifu_addr = 32'h8000_0040; lsu_addr = 32'h0000_0400; lsu_type = 3'b100;
        ifu_req = 1'b1; lsu_req = 1'b1;
        for (int r = 0; r < 6; r++) begin
            wait_gnt(who);
            chk($sformatf("tie_round%0d_winner", r), who, exp_who[r]);
            chk($sformatf("tie_round%0d_addr", r), mem_addr, (who == 1) ? 32'h400 : 32'h8000_0040);
            if (who == 1) lsu_req = 1'b0; else ifu_req = 1'b0;
            mem_ack = 1'b1; mem_rdata = 32'h1000 + r;
            tick();
            mem_ack = 1'b0;
            ifu_req = nxt_ifu[r]; lsu_req = nxt_lsu[r];
        end
        tick(); tick();

        // Single instruction fetch, minimum latency.
        ifu_req = 1'b1; ifu_addr = 32'h8000_0000;
        tick();
        chk("fetch_gnt",  ifu_gnt,  1'b1);
        chk("fetch_addr", mem_addr, 32'h8000_0000);
        chk("fetch_type", mem_type, 3'b010);
        ifu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0010_0073;
        tick();
        mem_ack = 1'b0;
        chk("fetch_rvalid", ifu_rvalid, 1'b1);
        chk("fetch_rdata",  ifu_rdata,  32'h0010_0073);
        tick();

        // Store: write-through fields, zero read data.
        lsu_req = 1'b1; lsu_we = 1'b1; lsu_type = 3'b000; lsu_addr = 32'h100; lsu_wdata = 32'hAB;
        tick();
        chk("store_we",    mem_we,    1'b1);
        chk("store_type",  mem_type,  3'b000);
        chk("store_wdata", mem_wdata, 32'hAB);
        lsu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        tick();
        mem_ack = 1'b0; lsu_we = 1'b0;
        chk("store_rvalid", lsu_rvalid, 1'b1);
        chk("store_rdata",  lsu_rdata,  32'h0);
        chk("fetch_hold",   ifu_rdata,  32'h0010_0073);
        tick();

        // LSU request that comes and goes while busy is never granted.
        ifu_req = 1'b1; ifu_addr = 32'h8000_0004;
        tick();
        ifu_req = 1'b0; lsu_req = 1'b1;
        tick();
        lsu_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
        tick();
        mem_ack = 1'b0;
        tick(); tick();
        chk("drop_idle", busy, 1'b0);

        // Acks while idle are ignored.
        mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        mem_ack = 1'b0;
        chk("idle_ack_no_rvalid", ifu_rvalid | lsu_rvalid, 1'b0);

        // Timeout with no ack.
        lsu_req = 1'b1; lsu_type = 3'b010; lsu_addr = 32'h200;
        tick();
        chk("tmo_gnt", lsu_gnt, 1'b1);
        lsu_req = 1'b0;
        tick(); tick(); tick();
        chk("tmo_pre_err",  err,  1'b0);
        chk("tmo_pre_busy", busy, 1'b1);
        tick();
        chk("tmo_err",    err,        1'b1);
        chk("tmo_rvalid", lsu_rvalid, 1'b1);
        chk("tmo_rdata",  lsu_rdata,  32'hDEADBEEF);
        chk("tmo_busy",   busy,       1'b0);
        tick();
        chk("tmo_err_pulse", err, 1'b0);

        // Reset mid-transaction, then a late ack.
        ifu_req = 1'b1; ifu_addr = 32'h8000_0010;
        tick();
        chk("rstmid_gnt", ifu_gnt, 1'b1);
        ifu_req = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("rstmid_mem_req", mem_req, 1'b0);
        chk("rstmid_busy",    busy,    1'b0);
        #1 rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        tick();
        mem_ack = 1'b0;
        chk("rstmid_no_rvalid", ifu_rvalid, 1'b0);
        chk("rstmid_idle",      mem_req,    1'b0);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all ports.
REQ-002 Parameter: DATA_W, 32, data width of all ports.
REQ-003 Parameter: TIMEOUT, 255, maximum wait cycles for mem_ack before abort; must be at least 1.
REQ-004 Port: clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: ifu_req  in  1  instruction-fetch read request; held until ifu_gnt.
REQ-007 Port: ifu_addr  in  ADDR_W  fetch address, i.e. the PC.
REQ-008 Port: ifu_gnt / ifu_rvalid  out  1 / 1  request accepted / read data valid; each a one-cycle pulse.
REQ-009 Port: ifu_rdata  out  DATA_W  fetched instruction.
REQ-010 Port: lsu_req, lsu_we  in  1, 1  load/store request; 1 = store.
REQ-011 Port: lsu_type  in  3  RV32 func3 access width/sign, passed through.
REQ-012 Port: lsu_addr / lsu_wdata  in  ADDR_W / DATA_W  load/store address and store data.
REQ-013 Port: lsu_gnt, lsu_rvalid  out  1, 1  pulses with the same meaning as the IFU pulses.
REQ-014 Port: lsu_rdata  out  DATA_W  load data.
REQ-015 Port: mem_req, mem_we  out  1, 1  downstream request and write enable.
REQ-016 Port: mem_type  out  3  downstream access type; 3'b010 for IFU accesses.
REQ-017 Port: mem_addr / mem_wdata  out  ADDR_W / DATA_W  downstream address and write data.
REQ-018 Port: mem_ack  in  1  downstream completion.
REQ-019 Port: mem_rdata  in  DATA_W  downstream read data, valid while mem_ack=1.
REQ-020 Port: busy / err  out  1 / 1  transaction in flight / one-cycle timeout pulse.

Function
REQ-021 The arbiter SHALL use the FSM states IDLE, IFU_WAIT and LSU_WAIT.
REQ-022 In IDLE with a request sampled at an edge, the FSM SHALL enter the winner's WAIT state at that edge, latch the winner's address, data, type and we, and pulse that requester's gnt in the following cycle.
REQ-023 mem_req SHALL be 1 exactly while in a WAIT state, and mem_* outputs SHALL remain stable from the latched values.
REQ-024 When mem_ack=1 at an edge in a WAIT state, the arbiter SHALL register mem_rdata (0 for stores), pulse the owner's rvalid for one cycle, and return to IDLE.
REQ-025 The minimum transaction time SHALL be 2 cycles (req to rvalid); a new grant SHALL be possible in the cycle rvalid is high.
REQ-026 Each WAIT state SHALL run a counter; on reaching TIMEOUT cycles without ack, the arbiter SHALL pulse err, pulse the owner's rvalid with rdata 32'hDEADBEEF, and go to IDLE.
REQ-027 mem_ack in IDLE SHALL be ignored.
REQ-028 A request deasserted before its grant SHALL be dropped silently.
REQ-029 On a simultaneous IFU and LSU request, the winner SHALL follow REQ-035.
REQ-030 rdata outputs SHALL hold their value until the next rvalid on that port.
REQ-031 busy SHALL equal (state != IDLE).

Reset
REQ-032 While rst=1, the state SHALL be IDLE, the counter 0, all gnt/rvalid/err/mem_req/mem_we outputs 0, and all data outputs 0.
REQ-033 rst asserted mid-transaction SHALL drop mem_req immediately (asynchronously), and no rvalid SHALL be issued for the aborted transaction.
REQ-034 The round-robin last-grant flag SHALL reset to IFU, so the LSU wins the first tie.

Configuration
REQ-035 With MEM_ARB_RR_EN defined, ties SHALL be resolved round-robin (the requester not granted last wins); without it, the LSU SHALL always win ties (fixed priority).

Structure
REQ-036 The package mem_arb_pkg SHALL hold the state enum, the IFU access type constant 3'b010, and the timeout poison word 32'hDEADBEEF.
REQ-037 Tie resolution SHALL be one sub-module, mem_arb_pick (inputs: two requests and the last-grant flag; outputs: one-hot grant), with the macro affecting only this sub-module.

Verification
REQ-038 ifu_req with addr 0x80000000, mem_ack one cycle later with rdata 0x00100073 -> ifu_gnt pulses in cycle 1, ifu_rvalid in cycle 2, ifu_rdata = 0x00100073.
REQ-039 ifu_req and lsu_req both asserted from IDLE, fixed priority -> LSU served first, then IFU; with MEM_ARB_RR_EN, four back-to-back ties -> grants alternate L,I,L,I.
REQ-040 lsu store (we=1, type 3'b000, addr 0x100, wdata 0xAB) -> mem_we=1, mem_type=0, mem_wdata=0xAB; lsu_rvalid with rdata 0.
REQ-041 TIMEOUT=4 with no mem_ack -> err and lsu_rvalid pulse after 4 WAIT cycles, rdata 0xDEADBEEF, busy=0 on the next cycle.
REQ-042 rst pulse during IFU_WAIT, followed by a late mem_ack -> no ifu_rvalid, state IDLE, mem_req=0.
